loadable_instr_rom: RTL

- Parametrised successor to the fixed-program instruction ROM.
- Holds the program in a writable array loaded at run time over a streaming load port.
- Registered 1-cycle fetch with stall and valid flag; array cleared to the default instruction on reset.
- Sits between the program counter (fetch address) and the decode stage; the loader is driven by the test host / boot logic.

---
 rtl/loadable_instr_rom_pkg.sv | 21 ++
 rtl/loadable_instr_rom_array.sv | 32 +++
 rtl/loadable_instr_rom.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/loadable_instr_rom_pkg.sv
// Shared instruction-set definitions for the fetch path and the decode stage.
// Instruction word layout (28 bits): {opcode[3:0], dest[7:0], src1[7:0], src0[7:0]}.
// A store-immediate uses {opcode, dest, imm[15:0]}.
// DEFAULT_INSTR_C is the NOP word returned by the ROM whenever no genuine
// instruction is available, so decode and fetch agree on what "nothing" is.
package loadable_instr_rom_pkg;

  localparam int OPCODE_W = 4;
  localparam int REG_W    = 8;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_STO = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;

  localparam logic [REG_W-1:0] REG_R0 = 8'h00;
  localparam logic [REG_W-1:0] REG_R1 = 8'h01;
  localparam logic [REG_W-1:0] REG_R2 = 8'h02;

  localparam logic [27:0] DEFAULT_INSTR_C = {OP_NOP, 24'd0};

endpackage

// File: rtl/loadable_instr_rom_array.sv
// Program storage for loadable_instr_rom.
// Ports:
//   clock  - system clock, write on rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (combinational read)
//   rdata  - read data
// The combinational read lets a word written on one edge be fetched on the
// very next edge, which the fetch path relies on when leaving a load.
module instr_mem_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 28,
  parameter int AW    = 8
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/loadable_instr_rom.sv
// Run-time loadable instruction ROM between the program counter and decode.
// Ports:
//   clock, reset   - system clock; synchronous active-high reset
//   address        - fetch address
//   enable         - fetch enable, 0 stalls (outputs hold)
//   instruction    - registered fetch result
//   valid          - instruction holds a genuine fetch result
//   load_start     - begin or restart a program load
//   load_valid     - load_data is a word to store this cycle
//   load_data      - load word
//   load_end       - finish the load and return to RUN
//   busy           - not in RUN
//   load_count     - words written by the current/last load
//   load_overflow  - sticky: a load word was dropped because the array was full
//
// state  | meaning
// CLEAR  | writing DEFAULT_INSTR through the whole array after reset
// RUN    | normal fetch; load_start enters LOAD
// LOAD   | streaming program words into the array; fetch suppressed
module loadable_instr_rom
  import loadable_instr_rom_pkg::*;
#(
  parameter int                     INSTR_WIDTH   = 28,
  parameter int                     ADDR_WIDTH    = 16,
  parameter int                     DEPTH         = 256,
  parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = DEFAULT_INSTR_C
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   enable,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   valid,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_end,
  output logic                   busy,
  output logic [ADDR_WIDTH:0]    load_count,
  output logic                   load_overflow
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH:0]    ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;

  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] mem_wdata;
  logic [INSTR_WIDTH-1:0] mem_rdata;
  logic                   in_range;
  logic                   ptr_full;

  // Pointer and address are compared one bit wider so DEPTH == 2**ADDR_WIDTH works.
  assign in_range = ({1'b0, address} < DEPTH_P);
  assign ptr_full = (ptr_q >= DEPTH_P);

  instr_mem_array #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_WIDTH),
    .AW    (MEM_AW)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .waddr (ptr_q[MEM_AW-1:0]),
    .wdata (mem_wdata),
    .raddr (address[MEM_AW-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      instr_q <= DEFAULT_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    mem_we    = 1'b0;
    mem_wdata = load_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = DEFAULT_INSTR;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == DEPTH_P - 1'b1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (enable) begin
          instr_d = in_range ? mem_rdata : DEFAULT_INSTR;
          valid_d = 1'b1;
        end
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        instr_d = DEFAULT_INSTR;
        valid_d = 1'b0;
        if (load_start) begin
          // Restart wins over end; any word offered alongside it is dropped.
          ptr_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          if (load_valid) begin
            if (ptr_full) begin
              ovf_d = 1'b1;
            end else begin
              mem_we  = 1'b1;
              ptr_d   = ptr_q + 1'b1;
              count_d = count_q + 1'b1;
            end
          end
          if (load_end) state_d = ST_RUN;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign busy          = (state_q != ST_RUN);
  assign instruction   = instr_q;
  assign valid         = valid_q;
  assign load_count    = count_q;
  assign load_overflow = ovf_q;

endmodule
